// File: rtl/edib_m5m7_clk_sched_pkg.sv
// Shared types and default constants for the EDIB M5/M7
// bit-clock scheduler.
package edib_pkg;

    localparam int EDIB_HALF_DIV = 32;
    localparam int EDIB_GUARD    = 4;
    localparam int EDIB_CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } edib_state_e;

endpackage

// File: rtl/edib_m5m7_clk_sched_if.sv
// Channel-side bundle of the M5/M7 clock scheduler:
// requests/lengths in, grants, bit clock and strobes out.
interface edib_m5m7_clk_sched_if #(
    parameter int CNT_W = edib_pkg::EDIB_CNT_W
);
    logic             req_m5;
    logic             req_m7;
    logic [CNT_W-1:0] len_m5;
    logic [CNT_W-1:0] len_m7;
    logic             gnt_m5;
    logic             gnt_m7;
    logic             sel_m7;
    logic             clk_m5m7;
    logic             bit_rise;
    logic             bit_fall;
    logic             done;
    logic             busy;

    modport master (
        output req_m5, req_m7, len_m5, len_m7,
        input  gnt_m5, gnt_m7, sel_m7, clk_m5m7,
        input  bit_rise, bit_fall, done, busy
    );

    modport slave (
        input  req_m5, req_m7, len_m5, len_m7,
        output gnt_m5, gnt_m7, sel_m7, clk_m5m7,
        output bit_rise, bit_fall, done, busy
    );

endinterface

// File: rtl/edib_m5m7_clk_sched_rr_arb2.sv
// Two-requester round-robin arbiter with a last-served
// pointer; bit 0 = M5, bit 1 = M7.
module edib_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);
    // 1: M7 was served last, so M5 wins the next tie
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (upd_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/edib_m5m7_clk_sched.sv
// EDIB M5/M7 shared bit-clock scheduler: burst grant,
// phase-aligned divided clock, edge strobes and guard gap.
module edib_m5m7_clk_sched
    import edib_pkg::*;
#(
    parameter int HALF_DIV = EDIB_HALF_DIV,
    parameter int CNT_W    = EDIB_CNT_W,
    parameter int GUARD    = EDIB_GUARD
) (
    input logic                  clk_12m_i,
    input logic                  reset_ni,
    edib_m5m7_clk_sched_if.slave bus
);
    localparam int DIV_W = $clog2(HALF_DIV);
    localparam int GAP_N = GUARD * HALF_DIV;
    localparam int GAP_W = (GAP_N > 1) ? $clog2(GAP_N) : 1;
    localparam int GAP_M = (GAP_N > 0) ? GAP_N - 1 : 0;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(HALF_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_M);
    localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);

    edib_state_e      state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_d;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;
    logic             gnt_m5_q;
    logic             gnt_m7_q;
    logic             sel_q;
    logic             clk_q;
    logic             rise_q;
    logic             fall_q;
    logic             done_q;
    logic             busy_q;

    logic [1:0]       arb_gnt;
    logic             arb_upd;

    assign arb_upd = (state_q == IDLE);
    assign div_d   = div_q + 1'b1;
    assign rem_d   = rem_q - 1'b1;
    assign gap_d   = gap_q + 1'b1;

    edib_rr_arb2 u_arb (
        .clk_i  (clk_12m_i),
        .rst_ni (reset_ni),
        .req_i  ({bus.req_m7, bus.req_m5}),
        .upd_i  (arb_upd),
        .gnt_o  (arb_gnt)
    );

    always_ff @(posedge clk_12m_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            div_q    <= '0;
            rem_q    <= '0;
            gap_q    <= '0;
            gnt_m5_q <= 1'b0;
            gnt_m7_q <= 1'b0;
            sel_q    <= 1'b0;
            clk_q    <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (arb_gnt != 2'b00) begin
                        gnt_m5_q <= arb_gnt[0];
                        gnt_m7_q <= arb_gnt[1];
                        sel_q    <= arb_gnt[1];
                        rem_q    <= arb_gnt[1] ? bus.len_m7
                                               : bus.len_m5;
                        div_q    <= '0;
                        clk_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (rem_q == '0) begin
                        // zero-length burst: one grant cycle, no gap
                        gnt_m5_q <= 1'b0;
                        gnt_m7_q <= 1'b0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (div_q == DIV_MAX) begin
                        div_q <= '0;
                        clk_q <= ~clk_q;
                        if (!clk_q) begin
                            rise_q <= 1'b1;
                        end else begin
                            fall_q <= 1'b1;
                            rem_q  <= rem_d;
                            if (rem_q == REM_ONE) begin
                                gnt_m5_q <= 1'b0;
                                gnt_m7_q <= 1'b0;
                                done_q   <= 1'b1;
                                gap_q    <= '0;
                                busy_q   <= (GAP_N != 0);
                                state_q  <= (GAP_N != 0) ? GAP
                                                         : IDLE;
                            end
                        end
                    end else begin
                        div_q <= div_d;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_MAX) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_d;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_m5   = gnt_m5_q;
    assign bus.gnt_m7   = gnt_m7_q;
    assign bus.sel_m7   = sel_q;
    assign bus.clk_m5m7 = clk_q;
    assign bus.bit_rise = rise_q;
    assign bus.bit_fall = fall_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;

endmodule
